vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Consumes the divide-by-4 pixel-rate tick from the clock divider (100 MHz system clk → 25 MHz pixel rate) and produces 640x480@60 VGA timing.
- Outputs: sync pulses, a visible-area flag and pixel coordinates for the cell renderer.
- Also produces a frame tick and a generation tick that pace the Game of Life update engine.
- Fully synchronous to the single system clock; pix_en is a clock enable, not a clock.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
FRAMES_PER_GEN, 30, frames between generation ticks (min 1)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
pix_en  input  1  one-clk-wide pixel-rate enable from the clock divider
run  input  1  1 = generation ticks free-run
step  input  1  single-cycle pulse; requests one generation tick while run=0
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
video_on  output  1  high while (x,y) is in the visible area
x  output  10  current horizontal count (0..H_TOTAL-1)
y  output  10  current vertical count (0..V_TOTAL-1)
frame_tick  output  1  one-clk pulse at start of each frame
gen_tick  output  1  one-clk pulse commanding the next generation

Behaviour:
- Derived totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Reset is synchronous and active-high. On a reset clk edge: h_cnt=0, v_cnt=0, frame counter=0, step_pending=0.
- Reset output values: x=0, y=0, hsync=1, vsync=1, video_on=1, frame_tick=0, gen_tick=0.
- Reset has priority over pix_en and step on the same edge. Reset mid-frame restarts at (0,0) with no frame_tick.
- Counters advance only on clk edges with pix_en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt wraps while v_cnt=V_TOTAL-1.
  - pix_en=0: all counters and outputs hold, except the pulse outputs, which return to 0.
- x, y, hsync, vsync and video_on are registered, updated on the same edge as the counters, and always reflect the current counter values. Zero lag between x/y and sync/video_on.
- hsync=0 iff H_VISIBLE+H_FRONT ≤ h_cnt ≤ H_VISIBLE+H_FRONT+H_SYNC-1 (656..751).
- vsync=0 iff V_VISIBLE+V_FRONT ≤ v_cnt ≤ V_VISIBLE+V_FRONT+V_SYNC-1 (490..491).
- video_on=1 iff h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
- frame_tick: high for exactly one clk cycle, the cycle immediately after the pix_en edge that moves (h,v) from (H_TOTAL-1,V_TOTAL-1) to (0,0).
- Frame counter (width ⌈log2(FRAMES_PER_GEN)⌉, min 1 bit):
  - With run=1, increments on each frame_tick edge.
  - On the frame_tick where it equals FRAMES_PER_GEN-1, it wraps to 0 and gen_tick pulses in that same cycle (aligned with frame_tick).
  - With run=0, the counter holds its value.
- step handling (only while run=0):
  - A step pulse sets step_pending.
  - On the next frame_tick, gen_tick pulses and step_pending clears.
  - Multiple steps within one frame collapse into a single gen_tick.
  - step while run=1 is ignored.
  - When run goes 0→1, step_pending clears.
- Simultaneous step and frame_tick while run=0: the step is honoured at that frame_tick (gen_tick=1).
- FRAMES_PER_GEN=1: gen_tick coincides with every frame_tick while run=1.
- gen_tick never asserts outside a frame_tick cycle, so generation swaps occur only during vertical blanking boundaries.

Test Plan:
- Reset, then pix_en every 4th clk for 800 enables → x steps 0..799 then returns to 0; y=1 after wrap. hsync=0 exactly for x=656..751 (96 pix_en periods = 384 clks). video_on=0 from x=640.
- Run one full frame (420000 enables) → vsync=0 only for y=490..491. frame_tick is a single 1-clk pulse, 1,680,000 clks after the previous one; x=y=0 in that cycle.
- FRAMES_PER_GEN=3, run=1 → gen_tick on the 3rd, 6th and 9th frame_tick only, each 1 clk wide.
- run=0, two step pulses mid-frame → exactly one gen_tick, at the next frame_tick. No gen_tick on later frames. Frame counter unchanged.
- pix_en held 0 for 100 clks mid-line at x=300 → x, y, hsync and video_on frozen. frame_tick and gen_tick stay 0.
- Assert reset at x=700, y=491 (hsync=0, vsync=0) → next cycle x=0, y=0, hsync=1, vsync=1, video_on=1, frame_tick=0. Pending step is cleared.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing from a pixel-rate clock enable, plus frame and generation pacing ticks.
// Outputs are registered and move together with the counters; pulses last one clk.
module vga_timing_gen #(
  parameter int H_VISIBLE      = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       run,
  input  logic       step,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_tick,
  output logic       gen_tick
);

  localparam int FCW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [FCW-1:0] F_LAST = FCW'(FRAMES_PER_GEN - 1);

  logic [9:0]     h_cnt_q, h_cnt_d;
  logic [9:0]     v_cnt_q, v_cnt_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           step_pending_q, step_pending_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           video_on_q, video_on_d;
  logic           frame_tick_q, frame_tick_d;
  logic           gen_tick_q, gen_tick_d;
  logic           h_wrap;
  logic           frame_wrap;

  assign h_wrap     = (h_cnt_q == H_LAST);
  assign frame_wrap = pix_en && h_wrap && (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end

    // Decode from the next counter values so sync/video_on carry no lag vs x/y.
    hsync_d    = !((h_cnt_d >= H_SYNC_LO) && (h_cnt_d <= H_SYNC_HI));
    vsync_d    = !((v_cnt_d >= V_SYNC_LO) && (v_cnt_d <= V_SYNC_HI));
    video_on_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);

    frame_tick_d   = frame_wrap;
    gen_tick_d     = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    step_pending_d = step_pending_q;
    if (run) begin
      // Pending steps are meaningless in free-run; dropping them also covers run 0->1.
      step_pending_d = 1'b0;
      if (frame_wrap) begin
        if (frame_cnt_q == F_LAST) begin
          frame_cnt_d = '0;
          gen_tick_d  = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + FCW'(1);
        end
      end
    end else if (frame_wrap) begin
      gen_tick_d     = step_pending_q || step;
      step_pending_d = 1'b0;
    end else if (step) begin
      step_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      frame_cnt_q    <= '0;
      step_pending_q <= 1'b0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      video_on_q     <= 1'b1;
      frame_tick_q   <= 1'b0;
      gen_tick_q     <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      step_pending_q <= step_pending_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_on_q     <= video_on_d;
      frame_tick_q   <= frame_tick_d;
      gen_tick_q     <= gen_tick_d;
    end
  end

  assign x          = h_cnt_q;
  assign y          = v_cnt_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = frame_tick_q;
  assign gen_tick   = gen_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, checked every clk against a linear-pixel-index model.
module tb_vga_timing_gen;
  localparam int HV = 10, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
  localparam int FPG  = 3;
  localparam int HT   = HV + HF + HS + HB;
  localparam int VT   = VV + VF + VS + VB;
  localparam int NPIX = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1, pix_en = 1'b0, run = 1'b1, step = 1'b0;
  logic       hsync, vsync, video_on, frame_tick, gen_tick;
  logic [9:0] x, y;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FRAMES_PER_GEN(FPG)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .run(run), .step(step),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .frame_tick(frame_tick), .gen_tick(gen_tick)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: a single pixel index since frame start, a run-mode frame count and a step request flag.
  int p = 0;
  int fcnt = 0;
  bit pend = 1'b0;
  bit e_ft = 1'b0;
  bit e_gt = 1'b0;
  bit armed = 1'b0;
  int n_gen = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    int ex, ey;
    ex = p % HT;
    ey = p / HT;
    check("x", int'(x), ex);
    check("y", int'(y), ey);
    check("hsync", int'(hsync), (ex >= HV + HF && ex < HV + HF + HS) ? 0 : 1);
    check("vsync", int'(vsync), (ey >= VV + VF && ey < VV + VF + VS) ? 0 : 1);
    check("video_on", int'(video_on), (ex < HV && ey < VV) ? 1 : 0);
    check("frame_tick", int'(frame_tick), int'(e_ft));
    check("gen_tick", int'(gen_tick), int'(e_gt));
  endtask

  task automatic model(input bit r, input bit pe, input bit rn, input bit st);
    if (r) begin
      p = 0; fcnt = 0; pend = 1'b0; e_ft = 1'b0; e_gt = 1'b0;
    end else begin
      e_ft = 1'b0;
      e_gt = 1'b0;
      if (pe) begin
        p++;
        if (p == NPIX) begin
          p = 0;
          e_ft = 1'b1;
        end
      end
      if (rn) begin
        pend = 1'b0;
        if (e_ft) begin
          fcnt++;
          if (fcnt == FPG) begin
            fcnt = 0;
            e_gt = 1'b1;
          end
        end
      end else if (e_ft) begin
        e_gt = pend || st;
        pend = 1'b0;
      end else if (st) begin
        pend = 1'b1;
      end
      if (e_gt) n_gen++;
    end
  endtask

  // Checks the outputs produced by the previous edge, then applies inputs for the next edge.
  task automatic tick(input bit r, input bit pe, input bit rn, input bit st);
    @(negedge clk);
    if (armed) check_outputs();
    reset = r; pix_en = pe; run = rn; step = st;
    model(r, pe, rn, st);
    armed = 1'b1;
  endtask

  function automatic bit rand_pe();
    return $urandom_range(0, 3) != 0;
  endfunction

  initial begin
    bit rn;
    bit hit;
    int g0;

    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b0);

    // Free-run generations with steps that must be ignored.
    for (int i = 0; i < 5000; i++)
      tick(1'b0, rand_pe(), 1'b1, $urandom_range(0, 7) == 0);

    // Stepped mode with sparse step pulses, often several per frame.
    g0 = n_gen;
    for (int i = 0; i < 3000; i++)
      tick(1'b0, rand_pe(), 1'b0, $urandom_range(0, 199) == 0);
    check("step_gens_seen", int'(n_gen > g0), 1);

    // Run toggling with frequent steps.
    rn = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) rn = !rn;
      tick(1'b0, rand_pe(), rn, $urandom_range(0, 19) == 0);
    end

    // Freeze mid-line for 100 clks.
    hit = 1'b0;
    for (int i = 0; i < 2 * NPIX && !hit; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      hit = (p % HT == 5) && (p / HT == 2);
    end
    check("reach_freeze_point", int'(hit), 1);
    for (int i = 0; i < 100; i++)
      tick(1'b0, 1'b0, 1'b1, $urandom_range(0, 1) == 1);

    // Reset inside both sync pulses with a step pending.
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 2 * NPIX && !hit; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      hit = (p % HT == HV + HF + 1) && (p / HT == VV + VF + 1) && pend;
    end
    check("reach_sync_point", int'(hit), 1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_video_on", int'(video_on), 1);
    check("rst_frame_tick", int'(frame_tick), 0);
    g0 = n_gen;
    for (int i = 0; i < 3 * NPIX; i++)
      tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("no_gen_after_reset_clears_step", n_gen - g0, 0);

    // Random mix including occasional resets.
    rn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rn = !rn;
      tick($urandom_range(0, 499) == 0, rand_pe(), rn, $urandom_range(0, 29) == 0);
    end

    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
